// File: rtl/pcpi_mul_arbiter.sv
// ---------------------------------------------------------------------------
// pcpi_mul_arbiter
//   Shares one PCPI multiply co-processor (MUL/MULH/MULHSU/MULHU) between
//   NUM_REQ PCPI requesters. Each requester port looks like a PCPI slave and
//   the co-processor port is a PCPI master. Claims are arbitrated round-robin.
//   The granted operands are registered and issued to the co-processor, and
//   the result is returned as a one-cycle ready pulse. A co-processor that
//   stalls for TIMEOUT_CYCLES cycles in ISSUE is abandoned. In that case the
//   requester gets an empty (wr=0) response and timeout_err pulses.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   req_valid       per-requester pcpi_valid          [NUM_REQ]
//   req_insn        per-requester pcpi_insn, slice i = [32*i+31:32*i]
//   req_rs1/rs2     per-requester operands, same slicing
//   req_wait        per-requester pcpi_wait (combinational)
//   req_ready       per-requester pcpi_ready, one-cycle pulse
//   req_wr          per-requester pcpi_wr
//   req_rd          shared result bus, zero outside the response cycle
//   co_valid/insn/rs1/rs2   request to the co-processor
//   co_ready/wr/rd          response from the co-processor
//   timeout_err     one-cycle pulse when an operation is aborted
// ---------------------------------------------------------------------------

// Per-requester decode: only the M-extension multiply group is claimed.
// This is funct7=0000001 on OP with funct3[2]=0. DIV/REM (funct3[2]=1) and
// every other instruction pass through unclaimed.
module pcpi_mul_claim (
   input  logic        valid_i,
   input  logic [31:0] insn_i,
   output logic        claim_o
);
   assign claim_o = valid_i
                  & (insn_i[6:0]   == 7'b0110011)
                  & (insn_i[31:25] == 7'b0000001)
                  & ~insn_i[14];
endmodule

module pcpi_mul_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_insn,
   input  logic [32*NUM_REQ-1:0] req_rs1,
   input  logic [32*NUM_REQ-1:0] req_rs2,
   output logic [NUM_REQ-1:0]    req_wait,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    req_wr,
   output logic [31:0]           req_rd,
   output logic                  co_valid,
   output logic [31:0]           co_insn,
   output logic [31:0]           co_rs1,
   output logic [31:0]           co_rs2,
   input  logic                  co_ready,
   input  logic                  co_wr,
   input  logic [31:0]           co_rd,
   output logic                  timeout_err
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_HOLD} state_t;

   // Lane views of the flat requester buses.
   logic [NUM_REQ-1:0][31:0] insn_v, rs1_v, rs2_v;
   assign insn_v = req_insn;
   assign rs1_v  = req_rs1;
   assign rs2_v  = req_rs2;

   state_t                state_q, state_d;
   // grant_q also serves as last_grant. It holds the owner of the current
   // operation, and in IDLE it is the starting point of the round-robin
   // search.
   logic [GW-1:0]         grant_q, grant_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  co_valid_q, co_valid_d;
   logic [31:0]           co_insn_q, co_insn_d;
   logic [31:0]           co_rs1_q, co_rs1_d;
   logic [31:0]           co_rs2_q, co_rs2_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]    req_wr_q, req_wr_d;
   logic [31:0]           req_rd_q, req_rd_d;
   logic                  timeout_q, timeout_d;

   logic [NUM_REQ-1:0]    claim;
   logic [GW-1:0]         pick, cand;
   logic                  found;

   // ---------------------------------------------------------------------
   // Per-requester decode and wait generation
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      pcpi_mul_claim u_claim (
         .valid_i (req_valid[i]),
         .insn_i  (insn_v[i]),
         .claim_o (claim[i])
      );
      // Wait covers the whole claim. It drops only in the response cycle
      // of the owning requester.
      assign req_wait[i] = claim[i] & ~((state_q == S_RESP) && (grant_q == GW'(i)));
   end

   // ---------------------------------------------------------------------
   // Round-robin pick: first claim strictly after grant_q, with wrap-around.
   // ---------------------------------------------------------------------
   always_comb begin
      pick  = grant_q;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(grant_q) + k) % NUM_REQ);
         if (!found && claim[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      cnt_d       = cnt_q;
      co_valid_d  = co_valid_q;
      co_insn_d   = co_insn_q;
      co_rs1_d    = co_rs1_q;
      co_rs2_d    = co_rs2_q;
      // Response outputs are pulses. They are loaded only on entry to
      // RESP, so they read zero everywhere else.
      req_ready_d = '0;
      req_wr_d    = '0;
      req_rd_d    = '0;
      timeout_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d    = pick;
               co_insn_d  = insn_v[pick];
               co_rs1_d   = rs1_v[pick];
               co_rs2_d   = rs2_v[pick];
               co_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // co_ready has priority over timeout expiry in the same cycle.
            if (co_ready) begin
               co_valid_d           = 1'b0;
               req_ready_d[grant_q] = 1'b1;
               req_wr_d[grant_q]    = co_wr;
               req_rd_d             = co_rd;
               state_d              = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               co_valid_d           = 1'b0;
               req_ready_d[grant_q] = 1'b1;
               timeout_d            = 1'b1;
               state_d              = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            // Valid may linger after ready. Wait for it to drop so that
            // the same request is not issued a second time.
            if (!req_valid[grant_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= GW'(NUM_REQ - 1);
         cnt_q       <= '0;
         co_valid_q  <= 1'b0;
         co_insn_q   <= '0;
         co_rs1_q    <= '0;
         co_rs2_q    <= '0;
         req_ready_q <= '0;
         req_wr_q    <= '0;
         req_rd_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         cnt_q       <= cnt_d;
         co_valid_q  <= co_valid_d;
         co_insn_q   <= co_insn_d;
         co_rs1_q    <= co_rs1_d;
         co_rs2_q    <= co_rs2_d;
         req_ready_q <= req_ready_d;
         req_wr_q    <= req_wr_d;
         req_rd_q    <= req_rd_d;
         timeout_q   <= timeout_d;
      end
   end

   assign co_valid    = co_valid_q;
   assign co_insn     = co_insn_q;
   assign co_rs1      = co_rs1_q;
   assign co_rs2      = co_rs2_q;
   assign req_ready   = req_ready_q;
   assign req_wr      = req_wr_q;
   assign req_rd      = req_rd_q;
   assign timeout_err = timeout_q;

endmodule
